// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and character helpers for the framed UART transmitter.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_GAP    = 3'd5
   } tx_state_e;

   function automatic int char_bits(input int data_bits, input int parity, input int stop_bits);
      return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
   endfunction

   function automatic logic parity_bit(input logic data_xor, input int parity);
      return (parity == PAR_ODD) ? ~data_xor : data_xor;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and raises o_bit_end during the terminal count.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 96
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_clear,
   output logic o_bit_end
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);

   if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
      $error("uart_baud_tick: CLKS_PER_BIT out of range 2..65535");
   end

   logic [CW-1:0] r_cnt;
   logic          r_bit_end;

   // Strobe is precomputed one count early so it is high exactly while r_cnt == LAST.
   always_ff @(posedge i_clock) begin
      if (i_reset || i_clear) begin
         r_cnt     <= '0;
         r_bit_end <= 1'b0;
      end else begin
         if (r_cnt == LAST) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
         r_bit_end <= (r_cnt == PRE_LAST);
      end
   end

   assign o_bit_end = r_bit_end;

endmodule

// File: rtl/uart_tx_frame.sv
// Word-oriented UART transmitter: BYTES characters per word, configurable parity,
// stop bits and inter-character gap, valid/ready handshake, all outputs registered.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 96,
   parameter int DATA_BITS    = 8,
   parameter int BYTES        = 2,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int GAP_BITS     = 1
) (
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic [BYTES*DATA_BITS-1:0] i_data,
   input  logic                       i_valid,
   output logic                       o_ready,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_tx
);

   localparam int W   = BYTES * DATA_BITS;
   localparam int CIW = $clog2(BYTES) + 1;
   localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic [3:0]     GAP_LAST  = 4'(GAP_BITS - 1);
   localparam logic [CIW-1:0] CHAR_LAST = CIW'(BYTES - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
      $error("uart_tx_frame: DATA_BITS out of range 5..9");
   end
   if (BYTES < 1 || BYTES > 8) begin : g_bad_bytes
      $error("uart_tx_frame: BYTES out of range 1..8");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_par
      $error("uart_tx_frame: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end
   if (GAP_BITS < 0 || GAP_BITS > 15) begin : g_bad_gap
      $error("uart_tx_frame: GAP_BITS out of range 0..15");
   end

   tx_state_e      r_state;
   logic [W-1:0]   r_word;
   logic [3:0]     r_bit_cnt;
   logic [CIW-1:0] r_char_idx;
   logic           r_par;
   logic           r_tx;
   logic           r_ready;
   logic           r_busy;
   logic           r_done;
   logic           w_accept;
   logic           w_bit_end;
   logic           w_tx_next;

   assign w_accept = (r_state == S_IDLE) && i_valid;

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_clear  (w_accept),
      .o_bit_end(w_bit_end)
   );

   // Line level for the current state; registered into r_tx, hence one cycle behind the FSM.
   always_comb begin
      w_tx_next = 1'b1;
      case (r_state)
         S_START:  w_tx_next = 1'b0;
         S_DATA:   w_tx_next = r_word[0];
         S_PARITY: w_tx_next = r_par;
         default:  w_tx_next = 1'b1;
      endcase
   end

   // Framing FSM; the word shifts right one bit per data bit, so the next character
   // lands in the low bits once the current one is sent.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_word     <= '0;
         r_bit_cnt  <= 4'd0;
         r_char_idx <= '0;
         r_par      <= 1'b0;
         r_tx       <= 1'b1;
         r_ready    <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_tx   <= w_tx_next;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_word     <= i_data;
                  r_bit_cnt  <= 4'd0;
                  r_char_idx <= '0;
                  r_busy     <= 1'b1;
                  r_ready    <= 1'b0;
                  r_state    <= S_START;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_par     <= parity_bit(^r_word[DATA_BITS-1:0], PARITY);
                  r_bit_cnt <= 4'd0;
                  r_state   <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_word <= r_word >> 1;
                  if (r_bit_cnt == DATA_LAST) begin
                     r_bit_cnt <= 4'd0;
                     r_state   <= (PARITY == PAR_NONE) ? S_STOP : S_PARITY;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
               end
            end
            S_PARITY: begin
               if (w_bit_end) begin
                  r_bit_cnt <= 4'd0;
                  r_state   <= S_STOP;
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  if (r_bit_cnt == STOP_LAST) begin
                     r_bit_cnt <= 4'd0;
                     if (r_char_idx == CHAR_LAST) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                     end else begin
                        r_char_idx <= r_char_idx + CIW'(1);
                        r_state    <= (GAP_BITS > 0) ? S_GAP : S_START;
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
               end
            end
            S_GAP: begin
               if (w_bit_end) begin
                  if (r_bit_cnt == GAP_LAST) begin
                     r_bit_cnt <= 4'd0;
                     r_state   <= S_START;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign o_tx    = r_tx;
   assign o_ready = r_ready;
   assign o_busy  = r_busy;
   assign o_done  = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: six parameterisations compared cycle by cycle
// against a waveform model built from the character-format rules.
module tb_uart_tx_frame;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // per-instance format: index 0=8N1x2 gap1, 1=8E1, 2=8O1, 3=7O2, 4=8N1x3 gap0 cpb2, 5=9E2x4 gap3 cpb3
   int cfg_cpb [6] = '{4, 4, 4, 4, 2, 3};
   int cfg_db  [6] = '{8, 8, 8, 7, 8, 9};
   int cfg_by  [6] = '{2, 1, 1, 1, 3, 4};
   int cfg_par [6] = '{0, 1, 2, 2, 0, 1};
   int cfg_stop[6] = '{1, 1, 1, 2, 1, 2};
   int cfg_gap [6] = '{1, 1, 1, 1, 0, 3};

   logic [15:0] data_a = '0; logic [7:0] data_e = '0; logic [7:0] data_o = '0;
   logic [6:0]  data_7 = '0; logic [23:0] data_z = '0; logic [35:0] data_f = '0;
   logic [5:0]  valid = '0;
   logic [5:0]  ready, busy, done, tx;

   uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .BYTES(2), .PARITY(0), .STOP_BITS(1), .GAP_BITS(1)) dut_a (
      .i_clock(clk), .i_reset(rst), .i_data(data_a), .i_valid(valid[0]),
      .o_ready(ready[0]), .o_busy(busy[0]), .o_done(done[0]), .o_tx(tx[0]));
   uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .BYTES(1), .PARITY(1), .STOP_BITS(1), .GAP_BITS(1)) dut_e (
      .i_clock(clk), .i_reset(rst), .i_data(data_e), .i_valid(valid[1]),
      .o_ready(ready[1]), .o_busy(busy[1]), .o_done(done[1]), .o_tx(tx[1]));
   uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .BYTES(1), .PARITY(2), .STOP_BITS(1), .GAP_BITS(1)) dut_o (
      .i_clock(clk), .i_reset(rst), .i_data(data_o), .i_valid(valid[2]),
      .o_ready(ready[2]), .o_busy(busy[2]), .o_done(done[2]), .o_tx(tx[2]));
   uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(7), .BYTES(1), .PARITY(2), .STOP_BITS(2), .GAP_BITS(1)) dut_7 (
      .i_clock(clk), .i_reset(rst), .i_data(data_7), .i_valid(valid[3]),
      .o_ready(ready[3]), .o_busy(busy[3]), .o_done(done[3]), .o_tx(tx[3]));
   uart_tx_frame #(.CLKS_PER_BIT(2), .DATA_BITS(8), .BYTES(3), .PARITY(0), .STOP_BITS(1), .GAP_BITS(0)) dut_z (
      .i_clock(clk), .i_reset(rst), .i_data(data_z), .i_valid(valid[4]),
      .o_ready(ready[4]), .o_busy(busy[4]), .o_done(done[4]), .o_tx(tx[4]));
   uart_tx_frame #(.CLKS_PER_BIT(3), .DATA_BITS(9), .BYTES(4), .PARITY(1), .STOP_BITS(2), .GAP_BITS(3)) dut_f (
      .i_clock(clk), .i_reset(rst), .i_data(data_f), .i_valid(valid[5]),
      .o_ready(ready[5]), .o_busy(busy[5]), .o_done(done[5]), .o_tx(tx[5]));

   logic exp_q[$];

   // observed vector {tx, busy, ready, done}
   function automatic logic [3:0] obs(input int s);
      return {tx[s], busy[s], ready[s], done[s]};
   endfunction

   task automatic set_data(input int s, input logic [71:0] w);
      case (s)
         0: data_a = w[15:0];
         1: data_e = w[7:0];
         2: data_o = w[7:0];
         3: data_7 = w[6:0];
         4: data_z = w[23:0];
         5: data_f = w[35:0];
         default: ;
      endcase
   endtask

   function automatic logic [71:0] rand72();
      return 72'({$urandom(), $urandom(), $urandom()});
   endfunction

   task automatic chk(input int s, input logic [3:0] e, input string tag, input int idx);
      logic [3:0] o;
      o = obs(s);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s dut%0d step%0d: {tx,busy,ready,done} observed %b expected %b", tag, s, idx, o, e);
      end
   endtask

   task automatic push_bit(input logic v, input int cpb);
      for (int c = 0; c < cpb; c++) exp_q.push_back(v);
   endtask

   // Expected line waveform, one entry per clock, from the first start-bit cycle to the last stop cycle.
   task automatic build_exp(input int s, input logic [71:0] w);
      logic [8:0] ch;
      int ones;
      logic p;
      exp_q.delete();
      for (int k = 0; k < cfg_by[s]; k++) begin
         ch = 9'(w >> (k * cfg_db[s]));
         ones = 0;
         push_bit(1'b0, cfg_cpb[s]);
         for (int b = 0; b < cfg_db[s]; b++) begin
            push_bit(ch[b], cfg_cpb[s]);
            ones += int'(ch[b]);
         end
         if (cfg_par[s] != 0) begin
            p = ((ones % 2) == 1);
            if (cfg_par[s] == 2) p = ~p;
            push_bit(p, cfg_cpb[s]);
         end
         for (int b = 0; b < cfg_stop[s]; b++) push_bit(1'b1, cfg_cpb[s]);
         if (k < cfg_by[s] - 1)
            for (int b = 0; b < cfg_gap[s]; b++) push_bit(1'b1, cfg_cpb[s]);
      end
   endtask

   // Called at the negedge right after the accepting edge. limit >= 0 stops early (for aborts).
   task automatic check_frame(input int s, input logic [71:0] w, input bit noise,
                              input logic after_valid, input int limit);
      int n;
      bit last;
      build_exp(s, w);
      n = exp_q.size();
      if (noise) begin valid[s] = 1'($urandom_range(0, 1)); set_data(s, rand72()); end
      chk(s, 4'b1100, "accept", 0);
      for (int i = 0; i < n; i++) begin
         if (limit >= 0 && i >= limit) return;
         @(negedge clk);
         last = (i == n - 1);
         chk(s, {exp_q[i], !last, last, last}, "frame", i + 1);
         if (last) valid[s] = after_valid;
         else if (noise) begin valid[s] = 1'($urandom_range(0, 1)); set_data(s, rand72()); end
      end
   endtask

   task automatic send(input int s, input logic [71:0] w, input bit noise);
      @(negedge clk);
      chk(s, 4'b1010, "pre_idle", 0);
      set_data(s, w);
      valid[s] = 1'b1;
      @(negedge clk);
      valid[s] = 1'b0;
      check_frame(s, w, noise, 1'b0, -1);
   endtask

   initial begin
      logic [71:0] w;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 6; s++) chk(s, 4'b1010, "reset_state", s);
      rst = 1'b0;

      send(0, 72'hA55A, 1'b0);   // 8N1 two characters, one gap bit
      send(1, 72'h07, 1'b0);     // even parity -> 1
      send(2, 72'h07, 1'b0);     // odd parity -> 0
      send(3, 72'h00, 1'b0);     // 7O2: parity 1, two stop bits
      send(4, 72'h00FF0F, 1'b0); // abutting characters, 2-cycle bits

      // valid held high across two words; data changes after acceptance must be ignored
      @(negedge clk);
      set_data(0, 72'h1234);
      valid[0] = 1'b1;
      @(negedge clk);
      set_data(0, 72'hBEEF);
      check_frame(0, 72'h1234, 1'b0, 1'b1, -1);
      @(negedge clk);
      valid[0] = 1'b0;
      check_frame(0, 72'hBEEF, 1'b1, 1'b0, -1);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk(0, 4'b1010, "no_extra_frame", i);
      end

      // abort during the third data bit of character 0
      w = rand72();
      @(negedge clk);
      set_data(0, w);
      valid[0] = 1'b1;
      @(negedge clk);
      valid[0] = 1'b0;
      check_frame(0, w, 1'b0, 1'b0, 14);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk(0, 4'b1010, "abort", 0);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk(0, 4'b1010, "abort_quiet", i);
      end
      send(0, rand72(), 1'b0);

      // randomized words with valid/data noise while busy
      for (int s = 0; s < 6; s++)
         for (int r = 0; r < 3; r++) send(s, rand72(), 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
